// File: rtl/csum_pkg.sv
// Shared constants, FSM state type and carry-fold helper for the streaming
// RFC 1071 one's-complement checksum accumulator.
package csum_pkg;

  localparam int CSUM_W    = 16;
  localparam int FOLD_IN_W = 64;

  typedef enum logic [1:0] {
    ACC,
    FOLD1,
    FOLD2,
    OUT
  } csum_state_t;

  // Complete end-around-carry fold of an accumulator zero-extended to FOLD_IN_W.
  function automatic logic [CSUM_W-1:0] fold(input logic [FOLD_IN_W-1:0] a);
    logic [CSUM_W+1:0] s;
    s = '0;
    for (int i = 0; i < FOLD_IN_W / CSUM_W; i++) begin
      s = s + {2'b00, a[i*CSUM_W +: CSUM_W]};
    end
    s = {2'b00, s[CSUM_W-1:0]} + {{CSUM_W{1'b0}}, s[CSUM_W+1:CSUM_W]};
    s = {2'b00, s[CSUM_W-1:0]} + {{CSUM_W{1'b0}}, s[CSUM_W+1:CSUM_W]};
    return s[CSUM_W-1:0];
  endfunction

endpackage

// File: rtl/csum_beat_sum.sv
// Combinational beat summer: zeroes bytes whose keep bit is clear, then adds the
// DATA_W/16 big-endian 16-bit words into a zero-extended ACC_W result.
module csum_beat_sum #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] keep,
  output logic [ACC_W-1:0]    beat_sum
);
  import csum_pkg::*;

  localparam int NB = DATA_W / 8;
  localparam int NW = DATA_W / CSUM_W;

  logic [DATA_W-1:0] masked;

  // keep[i] guards data[i*8 +: 8], so an odd trailing byte lands in a word's high half.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NB; i++) begin
      masked[i*8 +: 8] = data[i*8 +: 8] & {8{keep[i]}};
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int w = 0; w < NW; w++) begin
      beat_sum = beat_sum + ACC_W'(masked[w*CSUM_W +: CSUM_W]);
    end
  end

endmodule

// File: rtl/csum_stream_acc.sv
// Streaming one's-complement checksum: sums beats, two fold cycles, holds ~sum until m_ready.
// Last beat at edge N gives m_valid from N+2 (sampled at N+3); s_ready low outside ACC. Option: CSUM_STREAM_VERIFY_EN adds m_ok.
module csum_stream_acc #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  input  logic [15:0]         seed,
  output logic [15:0]         m_csum,
  output logic                m_valid,
`ifdef CSUM_STREAM_VERIFY_EN
  output logic                m_ok,
`endif
  input  logic                m_ready
);
  import csum_pkg::*;

  csum_state_t      state;
  logic             first;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] beat_sum;
  logic [ACC_W-1:0] acc_fold;
  logic [CSUM_W-1:0] acc_final;

  csum_beat_sum #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_beat_sum (
    .data     (s_data),
    .keep     (s_keep),
    .beat_sum (beat_sum)
  );

  assign acc_fold  = ACC_W'(acc[CSUM_W-1:0]) + ACC_W'(acc[ACC_W-1:CSUM_W]);
  // After FOLD1 the accumulator is at most 17 bits, so one more fold is exact here.
  assign acc_final = fold(FOLD_IN_W'(acc));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      first   <= 1'b1;
      acc     <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_csum  <= '0;
`ifdef CSUM_STREAM_VERIFY_EN
      m_ok    <= 1'b0;
`endif
    end else begin
      case (state)
        ACC: begin
          if (s_valid) begin
            acc   <= (first ? ACC_W'(seed) : acc) + beat_sum;
            first <= s_last;
            if (s_last) begin
              state   <= FOLD1;
              s_ready <= 1'b0;
            end
          end
        end
        FOLD1: begin
          acc   <= acc_fold;
          state <= FOLD2;
        end
        FOLD2: begin
          acc     <= acc_fold;
          m_csum  <= ~acc_final;
`ifdef CSUM_STREAM_VERIFY_EN
          m_ok    <= (acc_final == 16'hFFFF);
`endif
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            first   <= 1'b1;
            s_ready <= 1'b1;
            state   <= ACC;
          end
        end
        default: begin
          state   <= ACC;
          first   <= 1'b1;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csum_stream_acc.sv
// Scoreboard bench for csum_stream_acc: expected checksums are queued as packets
// are driven and compared when the DUT hands a result over.
`timescale 1ns/1ps
module tb_csum_stream_acc;

  localparam int DATA_W = 64;
  localparam int ACC_W  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] seed;
  logic [15:0] m_csum;
  logic        m_valid;
  logic        m_ready;
`ifdef CSUM_STREAM_VERIFY_EN
  logic        m_ok;
`endif

  int n_vec  = 0;
  int n_err  = 0;
  int n_out  = 0;
  int n_push = 0;

  logic [15:0] exp_q[$];
  logic        exp_ok_q[$];
  logic [63:0] pkt_beats[$];
  logic [15:0] mon_exp;
  logic        mon_ok;

  always #5 clk = ~clk;

  csum_stream_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .seed    (seed),
    .m_csum  (m_csum),
    .m_valid (m_valid),
`ifdef CSUM_STREAM_VERIFY_EN
    .m_ok    (m_ok),
`endif
    .m_ready (m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-serial reference: even bytes weigh 256, odd bytes 1, fold until 16 bits.
  function automatic logic [15:0] model(input logic [15:0] sd, input int nk);
    logic [63:0] s;
    logic [63:0] d;
    logic [7:0]  by;
    s = {48'h0, sd};
    for (int b = 0; b < pkt_beats.size(); b++) begin
      d = pkt_beats[b];
      for (int j = 0; j < 8; j++) begin
        by = ((b == pkt_beats.size() - 1) && (j >= nk)) ? 8'h00 : d[63-8*j -: 8];
        s = s + (((j % 2) == 0) ? {48'h0, by, 8'h00} : {56'h0, by});
      end
    end
    while ((s >> 16) != 64'h0) s = (s & 64'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic logic [7:0] mk_keep(input int n);
    logic [7:0] k;
    k = 8'hFF;
    if (n == 0) return 8'h00;
    k = k << (8 - n);
    return k;
  endfunction

  task automatic push_exp(input logic [15:0] c);
    exp_q.push_back(c);
    exp_ok_q.push_back(c == 16'h0000);
    n_push++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [15:0] sd);
    int t;
    t = 0;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    seed    = sd;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
    s_data  = 64'(64'hDEAD_BEEF_0BAD_F00D);
  endtask

  // Drives pkt_beats as one packet; only the first beat carries the real seed.
  task automatic send_pkt(input logic [15:0] sd, input int nk, input int gap);
    int nb;
    nb = pkt_beats.size();
    for (int b = 0; b < nb; b++) begin
      send_beat(pkt_beats[b], (b == nb - 1) ? mk_keep(nk) : 8'hFF, b == nb - 1,
                (b == 0) ? sd : 16'($urandom));
      if (b != nb - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk("bubble_s_ready", {31'h0, s_ready}, 1);
          tick();
        end
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_ok  = exp_ok_q.pop_front();
        chk("m_csum", {16'h0, m_csum}, {16'h0, mon_exp});
`ifdef CSUM_STREAM_VERIFY_EN
        chk("m_ok", {31'h0, m_ok}, {31'h0, mon_ok});
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nb;
    int nk;
    logic [15:0] sd;

    rst = 1'b1; s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0;
    seed = '0; m_ready = 1'b1;
    tick(); tick();
    chk("rst_s_ready", {31'h0, s_ready}, 1);
    chk("rst_m_valid", {31'h0, m_valid}, 0);
    chk("rst_m_csum", {16'h0, m_csum}, 0);
`ifdef CSUM_STREAM_VERIFY_EN
    chk("rst_m_ok", {31'h0, m_ok}, 0);
`endif
    rst = 1'b0;
    tick();

    // RFC 1071 example plus latency from the accepting edge N
    pkt_beats = {64'h0001_F203_F4F5_F6F7};
    push_exp(16'h220D);
    send_pkt(16'h0000, 8, 0);
    chk("fold_s_ready", {31'h0, s_ready}, 0);
    chk("lat_n0_valid", {31'h0, m_valid}, 0);
    tick();
    chk("lat_n1_valid", {31'h0, m_valid}, 0);
    tick();
    chk("lat_n2_valid", {31'h0, m_valid}, 1);
    drain();

    // Odd trailing byte sits in the high half of its word
    pkt_beats = {64'hAB00_0000_0000_0000};
    push_exp(16'h54FF);
    send_pkt(16'h0000, 1, 0);
    drain();

    // All-zero keep: result is just the complemented seed
    pkt_beats = {64'hFFFF_FFFF_FFFF_FFFF};
    push_exp(16'hEDCB);
    send_pkt(16'h1234, 0, 0);
    drain();

    // Two full beats with seed and valid bubbles
    pkt_beats = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    push_exp(16'hEDCB);
    send_pkt(16'h1234, 8, 3);
    drain();

    // Output backpressure with a new beat already waiting
    m_ready = 1'b0;
    pkt_beats = {64'h0001_F203_F4F5_F6F7};
    push_exp(16'h220D);
    push_exp(16'h54FF);
    send_pkt(16'h0000, 8, 0);
    s_data = 64'hAB00_0000_0000_0000; s_keep = 8'h80; s_last = 1'b1; seed = 16'h0000;
    s_valid = 1'b1;
    t = 0;
    while (!m_valid && t < 20) begin tick(); t++; end
    chk("bp_reach_out", {31'h0, m_valid}, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_m_valid", {31'h0, m_valid}, 1);
      chk("bp_m_csum", {16'h0, m_csum}, 16'h220D);
      chk("bp_s_ready", {31'h0, s_ready}, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_early_accept", {31'h0, s_ready}, 0);
    tick();
    chk("bp_post_hs_s_ready", {31'h0, s_ready}, 1);
    chk("bp_post_hs_m_valid", {31'h0, m_valid}, 0);
    tick();
    s_valid = 1'b0;
    chk("bp_beat_taken", {31'h0, s_ready}, 0);
    drain();

    // Reset in the middle of a packet leaves no residue
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 16'h5555);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_s_ready", {31'h0, s_ready}, 1);
    pkt_beats = {64'h0001_F203_F4F5_F6F7};
    push_exp(16'h220D);
    send_pkt(16'h0000, 8, 0);
    drain();

    // Received packet including its checksum: folded sum 0xFFFF gives 0x0000
    pkt_beats = {64'h0001_F203_F4F5_F6F7, 64'h220D_0000_0000_0000};
    push_exp(16'h0000);
    send_pkt(16'h0000, 2, 1);
    drain();
    pkt_beats = {64'h0001_F203_F4F5_F6F7, 64'h220E_0000_0000_0000};
    push_exp(16'hFFFE);
    send_pkt(16'h0000, 2, 0);
    drain();

    // Random packets against the byte-serial model
    for (int p = 0; p < 10; p++) begin
      nb = $urandom_range(1, 4);
      nk = $urandom_range(0, 8);
      sd = 16'($urandom);
      pkt_beats = {};
      for (int b = 0; b < nb; b++) pkt_beats.push_back({$urandom, $urandom});
      push_exp(model(sd, nk));
      send_pkt(sd, nk, $urandom_range(0, 2));
    end
    drain();

    chk("out_count", n_out, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
